// File: rtl/stdout_port.sv
// Memory-mapped console output port: buffers stored bytes in a FIFO, drains via valid/ready.
// Optional macro STDOUT_STALL_EN: backpressure the CPU on a full FIFO instead of dropping.
module stdout_port #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        stall,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PONE = 1;
   localparam logic [AW:0]   CONE = 1;
   localparam logic [AW:0]   CMAX = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count, count_nxt;
   logic          ovf, empty, full;
   logic          push_req, push_ok, pop;
   logic [8:0]    cnt_ext;
   logic          unused;

   assign hit      = addr[31:4] == BASE_ADDR[31:4];
   assign empty    = count == '0;
   assign full     = count == CMAX;
   assign pop      = char_valid && char_ready;
   assign push_req = hit && mem_write && addr[3:2] == 2'd0;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_ok  = push_req && (!full || pop);

   assign char_valid = !empty;
   assign char_out   = empty ? 8'h00 : mem[rd_ptr];

   assign cnt_ext = 9'(count);
   assign unused  = ^{addr[1:0], wdata[31:8], cnt_ext[8]};

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop})
         2'b10:   count_nxt = count + CONE;
         2'b01:   count_nxt = count - CONE;
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      rdata = 32'h0;
      if (hit && mem_read && addr[3:2] == 2'd1)
         rdata = {16'h0, cnt_ext[7:0], 5'h0, ovf, full, empty};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PONE;
         if (pop)     rd_ptr <= rd_ptr + PONE;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wr_ptr] <= wdata[7:0];
   end

`ifdef STDOUT_STALL_EN
   assign stall = push_req && full && !pop;
   assign ovf   = 1'b0;
`else
   logic drop, ovf_clr;

   assign stall   = 1'b0;
   assign drop    = push_req && full && !pop;
   assign ovf_clr = hit && mem_write && addr[3:2] == 2'd1 && wdata[2];

   // A drop wins over a clear landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)          ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_stdout_port.sv
// Directed self-checking bench for stdout_port (default build, drop-on-full).
module tb_stdout_port;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata;
   logic        mem_write, mem_read;
   logic        hit, stall, char_valid, char_ready;
   logic [31:0] rdata;
   logic [7:0]  char_out;

   int compared = 0;
   int mismatched = 0;

   stdout_port #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
      .mem_write(mem_write), .mem_read(mem_read), .hit(hit),
      .rdata(rdata), .stall(stall), .char_out(char_out),
      .char_valid(char_valid), .char_ready(char_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic rd_stat(input string tag, input logic [31:0] exp);
      addr = BASE + 32'd4;
      mem_read = 1'b1;
      #1;
      chk(tag, rdata, exp);
      mem_read = 1'b0;
      addr = 32'h0;
   endtask

   initial begin
      int np, ne;
      rst = 1'b1;
      addr = '0;
      wdata = '0;
      mem_write = 1'b0;
      mem_read = 1'b0;
      char_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset / idle
      chk("rst_valid", {31'h0, char_valid}, 32'h0);
      chk("rst_out", {24'h0, char_out}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      rd_stat("rst_status", 32'h0000_0001);
      addr = 32'h0000_0100;
      mem_read = 1'b1;
      #1;
      chk("miss_hit", {31'h0, hit}, 32'h0);
      chk("miss_rdata", rdata, 32'h0);
      mem_read = 1'b0;
      addr = BASE + 32'd4;
      #1;
      chk("noread_rdata", rdata, 32'h0);

      // two bytes, sink stalled
      wr(BASE, 32'h48);
      chk("push_valid", {31'h0, char_valid}, 32'h1);
      wr(BASE + 32'd1, 32'h69);
      rd_stat("two_status", 32'h0000_0200);
      chk("two_head", {24'h0, char_out}, 32'h48);
      addr = BASE;
      mem_read = 1'b1;
      #1;
      chk("txdata_read", rdata, 32'h0);
      mem_read = 1'b0;
      char_ready = 1'b1;
      #1;
      chk("drain0", {24'h0, char_out}, 32'h48);
      tick();
      chk("drain1", {24'h0, char_out}, 32'h69);
      tick();
      char_ready = 1'b0;
      chk("drained", {31'h0, char_valid}, 32'h0);

      // fill, overflow drop
      for (int i = 0; i < 8; i++) wr(BASE, 32'hA0 + i);
      rd_stat("full_status", 32'h0000_0802);
      addr = BASE;
      wdata = 32'hEE;
      mem_write = 1'b1;
      #1;
      chk("full_stall", {31'h0, stall}, 32'h0);
      tick();
      mem_write = 1'b0;
      rd_stat("ovf_status", 32'h0000_0806);
      wr(BASE + 32'd8, 32'h0);
      rd_stat("rsvd_status", 32'h0000_0806);
      char_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf_drain%0d", i), {24'h0, char_out}, 32'hA0 + i);
         tick();
      end
      char_ready = 1'b0;
      chk("ovf_empty", {31'h0, char_valid}, 32'h0);
      rd_stat("ovf_sticky", 32'h0000_0005);
      wr(BASE + 32'd4, 32'h4);
      rd_stat("ovf_clear", 32'h0000_0001);

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++) wr(BASE, 32'hB0 + i);
      addr = BASE;
      wdata = 32'hB8;
      mem_write = 1'b1;
      char_ready = 1'b1;
      #1;
      chk("pp_stall", {31'h0, stall}, 32'h0);
      tick();
      mem_write = 1'b0;
      char_ready = 1'b0;
      rd_stat("pp_status", 32'h0000_0802);
      char_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("pp_drain%0d", i), {24'h0, char_out}, 32'hB0 + i);
         tick();
      end
      char_ready = 1'b0;
      chk("pp_empty", {31'h0, char_valid}, 32'h0);

      // pointer wrap at mixed rates
      np = 0;
      ne = 0;
      for (int c = 0; c < 80 && ne < 20; c++) begin
         logic dp, dq;
         dp = (np < 20) && (c % 3 != 2) && (np - ne < 8);
         dq = (np - ne > 0) && (c % 4 != 0);
         addr = BASE;
         wdata = np;
         mem_write = dp;
         char_ready = dq;
         #1;
         if (dq) begin
            chk($sformatf("wrap_v%0d", ne), {31'h0, char_valid}, 32'h1);
            chk($sformatf("wrap_d%0d", ne), {24'h0, char_out}, ne);
         end
         tick();
         if (dp) np++;
         if (dq) ne++;
      end
      mem_write = 1'b0;
      char_ready = 1'b0;
      chk("wrap_count", ne, 20);
      chk("wrap_empty", {31'h0, char_valid}, 32'h0);

      // reset mid-drain
      for (int i = 0; i < 5; i++) wr(BASE, 32'hC0 + i);
      char_ready = 1'b1;
      chk("mid0", {24'h0, char_out}, 32'hC0);
      tick();
      chk("mid1", {24'h0, char_out}, 32'hC1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_valid", {31'h0, char_valid}, 32'h0);
      chk("mrst_out", {24'h0, char_out}, 32'h0);
      rd_stat("mrst_status", 32'h0000_0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mrst_quiet%0d", i), {31'h0, char_valid}, 32'h0);
      end
      char_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
